clk_div_monitor: RTL and testbench

- Receive-side checker for the fractional/odd clock dividers: samples a divided clock (sig_in) with the fast reference clock clk and measures its period and high time in clk cycles.
- Compares each measurement against expected values, maintains a lock indication and flags mismatches or a stopped clock.
- Sits beside divider outputs for on-chip self-check and bring-up debug.

---
 rtl/clk_div_monitor.sv | 187 ++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Receive-side checker for divided clocks: measures period and high time of sig_in
// in clk cycles, compares against expected values and reports lock, error and stuck.
module clk_div_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 3,
  parameter int EXP_HIGH   = 1,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_vld,
  output logic             locked,
  output logic             err,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  LOCK_V  = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_e;

  logic             sync1_q, sync_q, hist_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] quiet_cnt_q, quiet_cnt_d;
  logic [CNT_W-1:0] hi_snap_q, hi_snap_d;
  logic             fall_seen_q, fall_seen_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_vld_q, meas_vld_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;

  logic             rise, fall, edge_det, timeout_hit, match;
  logic [CNT_W-1:0] run_inc, quiet_inc;
  logic [MC_W-1:0]  match_inc;

  // Synchronizer and history flop run regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync_q  <= sync1_q;
      hist_q  <= sync_q;
    end
  end

  function automatic logic in_tol(input logic [CNT_W-1:0] val, input logic [CNT_W-1:0] exp_v);
    logic [CNT_W-1:0] diff;
    diff = (val >= exp_v) ? val - exp_v : exp_v - val;
    return diff <= TOL_V;
  endfunction

  assign rise      = sync_q & ~hist_q;
  assign fall      = ~sync_q & hist_q;
  assign edge_det  = rise | fall;
  assign run_inc   = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;
  assign quiet_inc = (quiet_cnt_q == CNT_MAX) ? quiet_cnt_q : quiet_cnt_q + CNT_ONE;
  assign match_inc = (match_cnt_q == LOCK_V) ? match_cnt_q : match_cnt_q + MC_W'(1);
  // Fires on the edge where the quiet counter would reach TIMEOUT; any edge wins.
  assign timeout_hit = !edge_det && (quiet_cnt_q == TO_TERM);
  // A period without a fall can never match, regardless of the stale snapshot.
  assign match = fall_seen_q && in_tol(run_cnt_q, EXP_P) && in_tol(hi_snap_q, EXP_H);

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = rise ? CNT_ONE : run_inc;
    quiet_cnt_d = edge_det ? CNT_ONE : quiet_inc;
    hi_snap_d   = fall ? run_cnt_q : hi_snap_q;
    fall_seen_d = rise ? 1'b0 : (fall ? 1'b1 : fall_seen_q);
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    meas_vld_d  = 1'b0;
    locked_d    = locked_q;
    err_d       = 1'b0;
    stuck_d     = edge_det ? 1'b0 : stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    case (state_q)
      IDLE: begin
        if (rise) state_d = ARM;
      end
      ARM, RUN: begin
        // The rise closing the ARM period is the first full period, so it is reported.
        if (rise) begin
          state_d    = RUN;
          period_d   = run_cnt_q;
          high_d     = fall_seen_q ? hi_snap_q : '0;
          meas_vld_d = 1'b1;
          if (match) begin
            match_cnt_d = match_inc;
            locked_d    = (match_inc == LOCK_V);
          end else begin
            err_d       = 1'b1;
            match_cnt_d = '0;
            locked_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      stuck_d     = 1'b1;
      stuck_lvl_d = sync_q;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      state_d     = IDLE;
    end

    if (!en) begin
      state_d     = IDLE;
      run_cnt_d   = '0;
      quiet_cnt_d = '0;
      match_cnt_d = '0;
      fall_seen_d = 1'b0;
      locked_d    = 1'b0;
      stuck_d     = 1'b0;
      stuck_lvl_d = stuck_lvl_q;
      meas_vld_d  = 1'b0;
      err_d       = 1'b0;
      period_d    = period_q;
      high_d      = high_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      hi_snap_q   <= '0;
      fall_seen_q <= 1'b0;
      match_cnt_q <= '0;
      period_q    <= '0;
      high_q      <= '0;
      meas_vld_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      hi_snap_q   <= hi_snap_d;
      fall_seen_q <= fall_seen_d;
      match_cnt_q <= match_cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      meas_vld_q  <= meas_vld_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign meas_vld  = meas_vld_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign stuck     = stuck_q;
  assign stuck_lvl = stuck_lvl_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: three instances cover default div-by-3,
// exact 8/3 with timeout 16, and an 8/3 with tolerance 1.
module tb_clk_div_monitor;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, b_rst_n, en_ac, b_en, a_sig, b_sig, c_sig;
  logic [CW-1:0] a_per, a_hi, b_per, b_hi, c_per, c_hi;
  logic a_meas, a_lock, a_err, a_stuck, a_slvl;
  logic b_meas, b_lock, b_err, b_stuck, b_slvl;
  logic c_meas, c_lock, c_err, c_stuck, c_slvl;

  clk_div_monitor u_a (
    .clk(clk), .rst_n(rst_n), .en(en_ac), .sig_in(a_sig),
    .period_o(a_per), .high_o(a_hi), .meas_vld(a_meas), .locked(a_lock),
    .err(a_err), .stuck(a_stuck), .stuck_lvl(a_slvl)
  );

  clk_div_monitor #(.EXP_PERIOD(8), .EXP_HIGH(3), .TOL(0), .TIMEOUT(16)) u_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .sig_in(b_sig),
    .period_o(b_per), .high_o(b_hi), .meas_vld(b_meas), .locked(b_lock),
    .err(b_err), .stuck(b_stuck), .stuck_lvl(b_slvl)
  );

  clk_div_monitor #(.EXP_PERIOD(8), .EXP_HIGH(3), .TOL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_ac), .sig_in(c_sig),
    .period_o(c_per), .high_o(c_hi), .meas_vld(c_meas), .locked(c_lock),
    .err(c_err), .stuck(c_stuck), .stuck_lvl(c_slvl)
  );

  int n_chk = 0;
  int n_pass = 0;

  int a_n = 0, a_lock_at = 0, a_errs = 0, a_last_per = 0, a_last_hi = 0;
  int b_n = 0, b_errs = 0;
  int c_n = 0, c_errs = 0;
  int b_per_log [64];
  int b_hi_log  [64];
  int b_err_log [64];
  int b_lck_log [64];
  int c_per_log [64];
  int c_err_log [64];
  int c_lck_log [64];
  int c_pers [9] = '{8, 7, 9, 8, 7, 9, 8, 10, 8};

  // Record every measurement strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (a_meas) begin
      a_n        <= a_n + 1;
      a_last_per <= int'(a_per);
      a_last_hi  <= int'(a_hi);
      if (a_lock && a_lock_at == 0) a_lock_at <= a_n + 1;
    end
    if (a_err) a_errs <= a_errs + 1;
    if (b_meas && b_n < 63) begin
      b_n                <= b_n + 1;
      b_per_log[b_n + 1] <= int'(b_per);
      b_hi_log[b_n + 1]  <= int'(b_hi);
      b_err_log[b_n + 1] <= int'(b_err);
      b_lck_log[b_n + 1] <= int'(b_lock);
    end
    if (b_err) b_errs <= b_errs + 1;
    if (c_meas && c_n < 63) begin
      c_n                <= c_n + 1;
      c_per_log[c_n + 1] <= int'(c_per);
      c_err_log[c_n + 1] <= int'(c_err);
      c_lck_log[c_n + 1] <= int'(c_lock);
    end
    if (c_err) c_errs <= c_errs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic set_sig(input int which, input logic v);
    case (which)
      0:       a_sig = v;
      1:       b_sig = v;
      default: c_sig = v;
    endcase
  endtask

  // One period of `per` cycles with the first `hi` cycles high.
  task automatic drive_period(input int which, input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      set_sig(which, i < hi);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; b_rst_n = 1'b0; en_ac = 1'b1; b_en = 1'b1;
    a_sig = 1'b0; b_sig = 1'b0; c_sig = 1'b0;
    idle(2);
    chk("rst_period", 32'(b_per), 0);
    chk("rst_high", 32'(b_hi), 0);
    chk("rst_meas_vld", 32'(b_meas), 0);
    chk("rst_locked", 32'(b_lock), 0);
    chk("rst_err", 32'(b_err), 0);
    chk("rst_stuck", 32'(b_stuck), 0);
    chk("rst_stuck_lvl", 32'(b_slvl), 0);
    @(negedge clk);
    rst_n = 1'b1; b_rst_n = 1'b1;
    idle(21);
    chk("b_idle_stuck", 32'(b_stuck), 1);
    chk("b_idle_stuck_lvl", 32'(b_slvl), 0);
    chk("b_idle_no_meas", b_n, 0);

    // Ideal divide-by-3 on defaults: 11 rises give 10 measurements.
    repeat (11) drive_period(0, 3, 1);
    idle(2);
    chk("a_meas_count", a_n, 10);
    chk("a_lock_at", a_lock_at, 4);
    chk("a_period", a_last_per, 3);
    chk("a_high", a_last_hi, 1);
    chk("a_err_count", a_errs, 0);

    // Period 8 / high 3, with the low phase of period 7 stretched by one cycle.
    for (int p = 1; p <= 12; p++) drive_period(1, (p == 7) ? 9 : 8, 3);
    chk("b_stuck_cleared", 32'(b_stuck), 0);
    chk("b_m3_locked", b_lck_log[3], 0);
    chk("b_m4_locked", b_lck_log[4], 1);
    chk("b_m6_period", b_per_log[6], 8);
    chk("b_m6_high", b_hi_log[6], 3);
    chk("b_m6_err", b_err_log[6], 0);
    chk("b_m7_period", b_per_log[7], 9);
    chk("b_m7_high", b_hi_log[7], 3);
    chk("b_m7_err", b_err_log[7], 1);
    chk("b_m7_locked", b_lck_log[7], 0);
    chk("b_m10_locked", b_lck_log[10], 0);
    chk("b_m11_locked", b_lck_log[11], 1);

    // Rise then hold high: stuck exactly 16 cycles after the rise strobe.
    b_sig = 1'b1;
    idle(17);
    chk("b_meas_count_12", b_n, 12);
    chk("b_m12_locked", b_lck_log[12], 1);
    chk("b_stuck_early", 32'(b_stuck), 0);
    chk("b_locked_pre_stuck", 32'(b_lock), 1);
    idle(1);
    chk("b_stuck_set", 32'(b_stuck), 1);
    chk("b_stuck_lvl_high", 32'(b_slvl), 1);
    chk("b_stuck_unlock", 32'(b_lock), 0);
    idle(5);
    drive_period(1, 5, 0);
    chk("b_stuck_fall_clear", 32'(b_stuck), 0);
    drive_period(1, 8, 3);
    chk("b_no_meas_first_rise", b_n, 12);
    drive_period(1, 8, 3);
    chk("b_meas_second_rise", b_n, 13);
    chk("b_m13_period", b_per_log[13], 8);
    repeat (4) drive_period(1, 8, 3);
    chk("b_meas_count_17", b_n, 17);
    chk("b_relocked", 32'(b_lock), 1);
    chk("b_total_errs", b_errs, 1);

    // Drop en for 5 cycles mid-period.
    drive_period(1, 4, 3);
    b_en = 1'b0;
    drive_period(1, 5, 0);
    chk("b_en_unlock", 32'(b_lock), 0);
    chk("b_en_period_held", 32'(b_per), 8);
    chk("b_en_no_meas", b_n, 18);
    b_en = 1'b1;
    drive_period(1, 2, 0);
    drive_period(1, 8, 3);
    chk("b_en_first_rise", b_n, 18);
    drive_period(1, 8, 3);
    chk("b_en_second_rise", b_n, 19);

    // Asynchronous reset between a fall and the next rise.
    drive_period(1, 6, 3);
    chk("b_meas_count_20", b_n, 20);
    b_rst_n = 1'b0;
    #2;
    chk("b_async_rst_period", 32'(b_per), 0);
    chk("b_async_rst_high", 32'(b_hi), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_rst_n = 1'b1;
    idle(1);
    drive_period(1, 2, 0);
    drive_period(1, 8, 3);
    chk("b_rst_first_rise", b_n, 20);
    drive_period(1, 8, 3);
    chk("b_rst_second_rise", b_n, 21);
    chk("b_m21_period", b_per_log[21], 8);

    // Tolerance 1 against 8: 7/8/9 match, 10 does not.
    for (int i = 0; i < 9; i++) drive_period(2, c_pers[i], 3);
    chk("c_meas_count", c_n, 8);
    chk("c_m2_period", c_per_log[2], 7);
    chk("c_m3_period", c_per_log[3], 9);
    chk("c_m7_locked", c_lck_log[7], 1);
    chk("c_m7_err", c_err_log[7], 0);
    chk("c_m8_period", c_per_log[8], 10);
    chk("c_m8_err", c_err_log[8], 1);
    chk("c_m8_locked", c_lck_log[8], 0);
    chk("c_err_count", c_errs, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
